flash_mp_region_cfg: RTL and testbench

Configuration holder and producer for the flash memory-protection data-region attribute array. It drives the `data_region_attr_t` array consumed by the data-region selector. Writes are staged per region through a request/acknowledge port, then committed to the live array by a sequential scan. Regions can be locked against further change. The block sits between the flash_ctrl register interface and the memory-protection logic.

---
 rtl/flash_mp_region_cfg_if.sv | 63 ++++++
 rtl/flash_mp_region_cfg.sv | 146 ++++++++++++++
 tb/tb_flash_mp_region_cfg.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/flash_mp_region_cfg_if.sv
// Attribute type and request/acknowledge bundle for flash_mp_region_cfg.
//
// flash_ctrl_pkg supplies data_region_attr_t and HwDataAttr, the power-on data-region attribute.
// Its phase bit is the LSB.
//
// flash_mp_region_cfg_if groups the staged-write, commit and readback signals.
// - master: the register-interface side, which issues requests.
// - slave:  the flash_mp_region_cfg side.
//
// Signals:
//   wr_req/wr_idx/wr_attr/wr_lock  staged-write request, held until wr_ack
//   wr_ack/wr_err                  one-cycle acknowledge; wr_err marks a rejected write
//   commit/busy/cfg_update         commit pulse, scan-in-progress flag, scan-finished pulse
//   rd_req/rd_idx                  readback request
//   rd_valid/rd_attr               readback response, one cycle after the request

package flash_ctrl_pkg;

  typedef struct packed {
    logic en;
    logic rd_en;
    logic prog_en;
    logic erase_en;
    logic scramble_en;
    logic ecc_en;
    logic he_en;
    logic phase;
  } data_region_attr_t;

  parameter data_region_attr_t HwDataAttr [1] = '{'{phase: 1'b1, default: 1'b0}};

endpackage

interface flash_mp_region_cfg_if #(
  parameter int unsigned NumRegions = 4,
  parameter int unsigned IdxW       = (NumRegions > 1) ? $clog2(NumRegions) : 1
);

  logic                            wr_req;
  logic [IdxW-1:0]                 wr_idx;
  flash_ctrl_pkg::data_region_attr_t wr_attr;
  logic                            wr_lock;
  logic                            wr_ack;
  logic                            wr_err;
  logic                            commit;
  logic                            busy;
  logic                            cfg_update;
  logic                            rd_req;
  logic [IdxW-1:0]                 rd_idx;
  logic                            rd_valid;
  flash_ctrl_pkg::data_region_attr_t rd_attr;

  modport master (
    output wr_req, wr_idx, wr_attr, wr_lock, commit, rd_req, rd_idx,
    input  wr_ack, wr_err, busy, cfg_update, rd_valid, rd_attr
  );

  modport slave (
    input  wr_req, wr_idx, wr_attr, wr_lock, commit, rd_req, rd_idx,
    output wr_ack, wr_err, busy, cfg_update, rd_valid, rd_attr
  );

endinterface

// File: rtl/flash_mp_region_cfg.sv
// Staged configuration holder for the flash memory-protection data-region attributes.
//
// Writes land in a per-region staging slot. A commit pulse then scans every region and copies
// the dirty, unlocked entries into the live array that feeds the region selector. A region can
// be locked at commit time; after that it rejects every write until reset.
//
// Ports:
//   clk_i           clock
//   rst_i           synchronous, active-high reset
//   bus             slave side of flash_mp_region_cfg_if (write / commit / readback)
//   region_attrs_o  live attribute array
//   lock_o          per-region lock status

module flash_mp_region_cfg
  import flash_ctrl_pkg::*;
#(
  parameter int unsigned NumRegions = 4,
  parameter int unsigned IdxW       = (NumRegions > 1) ? $clog2(NumRegions) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  flash_mp_region_cfg_if.slave    bus,
  output data_region_attr_t       region_attrs_o [NumRegions],
  output logic [NumRegions-1:0]   lock_o
);

  localparam int unsigned CntW = (NumRegions > 1) ? $clog2(NumRegions) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(NumRegions - 1);

  typedef enum logic [1:0] {StIdle, StWack, StCommit, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cidx_q, cidx_d;
  logic              err_q, err_d;
  logic              rd_valid_q;
  data_region_attr_t rd_attr_q;

  data_region_attr_t     live_q   [NumRegions];
  data_region_attr_t     staged_q [NumRegions];
  logic [NumRegions-1:0] dirty_q, lockp_q, lock_q;

  logic [NumRegions-1:0] wr_hit, rd_hit, cidx_hit;
  logic                  wr_bad, stage_en, commit_en;
  data_region_attr_t     rd_data;

  // One-hot decode of each index. An index outside the array decodes to all-zero, which marks
  // an out-of-range write and makes an out-of-range read return zero.
  always_comb begin
    wr_hit   = '0;
    rd_hit   = '0;
    cidx_hit = '0;
    for (int i = 0; i < int'(NumRegions); i++) begin
      wr_hit[i]   = (32'(bus.wr_idx) == i);
      rd_hit[i]   = (32'(bus.rd_idx) == i);
      cidx_hit[i] = (32'(cidx_q) == i);
    end
  end

  assign wr_bad = ~|wr_hit | |(wr_hit & lock_q);

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < int'(NumRegions); i++) begin
      if (rd_hit[i]) rd_data = live_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    cidx_d    = cidx_q;
    err_d     = err_q;
    stage_en  = 1'b0;
    commit_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A commit wins over a simultaneous write; the write stays pending until after DONE.
        if (bus.commit) begin
          state_d = StCommit;
          cidx_d  = '0;
        end else if (bus.wr_req) begin
          state_d  = StWack;
          err_d    = wr_bad;
          stage_en = ~wr_bad;
        end
      end
      StWack: state_d = StIdle;
      StCommit: begin
        commit_en = 1'b1;
        if (cidx_q == LastIdx) begin
          state_d = StDone;
          cidx_d  = '0;
        end else begin
          cidx_d = cidx_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cidx_q     <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_attr_q  <= '0;
      dirty_q    <= '0;
      lockp_q    <= '0;
      lock_q     <= '0;
      for (int i = 0; i < int'(NumRegions); i++) begin
        live_q[i]   <= HwDataAttr[0];
        staged_q[i] <= HwDataAttr[0];
      end
    end else begin
      state_q    <= state_d;
      cidx_q     <= cidx_d;
      err_q      <= err_d;
      rd_valid_q <= bus.rd_req;
      if (bus.rd_req) rd_attr_q <= rd_data;
      for (int i = 0; i < int'(NumRegions); i++) begin
        // Staging happens only in IDLE and committing only in COMMIT, so these never overlap.
        if (stage_en && wr_hit[i]) begin
          staged_q[i] <= bus.wr_attr;
          dirty_q[i]  <= 1'b1;
          lockp_q[i]  <= lockp_q[i] | bus.wr_lock;
        end
        if (commit_en && cidx_hit[i] && dirty_q[i] && !lock_q[i]) begin
          live_q[i]  <= staged_q[i];
          dirty_q[i] <= 1'b0;
          lock_q[i]  <= lockp_q[i];
        end
      end
    end
  end

  assign bus.wr_ack     = (state_q == StWack);
  assign bus.wr_err     = (state_q == StWack) & err_q;
  assign bus.busy       = (state_q == StCommit);
  assign bus.cfg_update = (state_q == StDone);
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_attr    = rd_attr_q;
  assign region_attrs_o = live_q;
  assign lock_o         = lock_q;

endmodule

// File: tb/tb_flash_mp_region_cfg.sv
module tb_flash_mp_region_cfg;
  import flash_ctrl_pkg::*;

  localparam int unsigned NumRegions = 4;
  localparam int unsigned IdxW       = 3;  // wide enough to drive out-of-range indices
  localparam logic [7:0]  Rst        = 8'h01;  // phase=1, everything else 0

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  data_region_attr_t     region_attrs [NumRegions];
  logic [NumRegions-1:0] lock;

  flash_mp_region_cfg_if #(.NumRegions(NumRegions), .IdxW(IdxW)) bus ();

  flash_mp_region_cfg #(.NumRegions(NumRegions), .IdxW(IdxW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .bus            (bus),
    .region_attrs_o (region_attrs),
    .lock_o         (lock)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_regions(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
    check_eq({tag, " r0"}, 32'(region_attrs[0]), 32'(e0));
    check_eq({tag, " r1"}, 32'(region_attrs[1]), 32'(e1));
    check_eq({tag, " r2"}, 32'(region_attrs[2]), 32'(e2));
    check_eq({tag, " r3"}, 32'(region_attrs[3]), 32'(e3));
  endtask

  // Request in the current cycle, check the acknowledge one cycle later, return in IDLE.
  task automatic do_write(input string tag, input logic [IdxW-1:0] idx, input logic [7:0] attr,
                          input logic lk, input logic exp_err);
    bus.wr_req  = 1'b1;
    bus.wr_idx  = idx;
    bus.wr_attr = data_region_attr_t'(attr);
    bus.wr_lock = lk;
    tick();
    check_eq({tag, " ack"}, 32'(bus.wr_ack), 32'(1));
    check_eq({tag, " err"}, 32'(bus.wr_err), 32'(exp_err));
    bus.wr_req  = 1'b0;
    bus.wr_lock = 1'b0;
    tick();
  endtask

  // Commit pulse at cycle N; walk cycles N+1..N+6 checking busy, cfg_update and region r.
  task automatic do_commit(input string tag, input int r, input logic [7:0] old_v,
                           input logic [7:0] new_v);
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      check_eq($sformatf("%s busy@%0d", tag, k), 32'(bus.busy), 32'(k <= 4));
      check_eq($sformatf("%s cfg@%0d", tag, k), 32'(bus.cfg_update), 32'(k == 5));
      check_eq($sformatf("%s r%0d@%0d", tag, r, k), 32'(region_attrs[r]),
               32'((k >= r + 2) ? new_v : old_v));
      if (k < 6) tick();
    end
  endtask

  task automatic do_read(input string tag, input logic [IdxW-1:0] idx, input logic [7:0] exp);
    bus.rd_req = 1'b1;
    bus.rd_idx = idx;
    tick();
    bus.rd_req = 1'b0;
    check_eq({tag, " valid"}, 32'(bus.rd_valid), 32'(1));
    check_eq({tag, " data"}, 32'(bus.rd_attr), 32'(exp));
  endtask

  initial begin
    bus.wr_req  = 1'b0;
    bus.wr_idx  = '0;
    bus.wr_attr = '0;
    bus.wr_lock = 1'b0;
    bus.commit  = 1'b0;
    bus.rd_req  = 1'b0;
    bus.rd_idx  = '0;
    tick();
    tick();
    rst_i = 1'b0;

    // Reset state
    check_regions("reset", Rst, Rst, Rst, Rst);
    check_eq("reset lock", 32'(lock), 32'(0));
    check_eq("reset busy", 32'(bus.busy), 32'(0));
    check_eq("reset cfg", 32'(bus.cfg_update), 32'(0));
    check_eq("reset ack", 32'(bus.wr_ack), 32'(0));
    check_eq("reset err", 32'(bus.wr_err), 32'(0));
    check_eq("reset rdv", 32'(bus.rd_valid), 32'(0));
    check_eq("reset rda", 32'(bus.rd_attr), 32'(0));

    do_read("rd2", 3'd2, Rst);
    tick();
    check_eq("rd2 valid drop", 32'(bus.rd_valid), 32'(0));
    check_eq("rd2 hold", 32'(bus.rd_attr), 32'(Rst));

    // Staged write is invisible until commit; region 1 appears at commit+3
    do_write("w1", 3'd1, 8'hA4, 1'b0, 1'b0);
    check_regions("w1 staged", Rst, Rst, Rst, Rst);
    do_commit("c1", 1, Rst, 8'hA4);
    check_regions("c1 after", Rst, 8'hA4, Rst, Rst);
    do_read("rd1", 3'd1, 8'hA4);

    // Lock region 0, then a second write is rejected and a further commit changes nothing
    do_write("w0lk", 3'd0, 8'h33, 1'b1, 1'b0);
    do_commit("c0", 0, Rst, 8'h33);
    check_eq("lock0", 32'(lock), 32'(4'b0001));
    do_write("w0 locked", 3'd0, 8'h55, 1'b0, 1'b1);
    do_commit("c0b", 0, 8'h33, 8'h33);
    check_eq("lock0 kept", 32'(lock), 32'(4'b0001));

    // Out-of-range write: error, and an empty commit still pulses cfg_update
    do_write("w5", 3'd5, 8'hFF, 1'b0, 1'b1);
    do_commit("c5", 2, Rst, Rst);
    check_regions("c5 after", 8'h33, 8'hA4, Rst, Rst);
    do_read("rd6", 3'd6, 8'h00);

    // Commit and write together: commit first, write acked at DONE+2, applied at next commit
    bus.wr_req  = 1'b1;
    bus.wr_idx  = 3'd2;
    bus.wr_attr = data_region_attr_t'(8'h66);
    do_commit("cw", 2, Rst, Rst);
    check_eq("cw ack idle", 32'(bus.wr_ack), 32'(0));
    tick();
    check_eq("cw ack", 32'(bus.wr_ack), 32'(1));
    check_eq("cw err", 32'(bus.wr_err), 32'(0));
    bus.wr_req = 1'b0;
    tick();
    check_regions("cw staged", 8'h33, 8'hA4, Rst, Rst);
    do_commit("cw2", 2, Rst, 8'h66);

    // Reset in cycle 2 of a scan, the same edge that would commit region 1
    do_write("w1b", 3'd1, 8'hC2, 1'b0, 1'b0);
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_regions("mid rst", Rst, Rst, Rst, Rst);
    check_eq("mid rst lock", 32'(lock), 32'(0));
    check_eq("mid rst busy", 32'(bus.busy), 32'(0));
    for (int k = 0; k < 6; k++) begin
      check_eq($sformatf("mid rst cfg@%0d", k), 32'(bus.cfg_update), 32'(0));
      tick();
    end
    // Dirty bits were cleared too, so a fresh commit leaves region 1 at reset
    do_commit("post rst", 1, Rst, Rst);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
